// File: rtl/sseg_scan_mux.sv
// -----------------------------------------------------------------------------
// sseg_scan_mux
//
// Time-multiplexed seven-segment display driver for NDIG digits with
// active-low anodes and segments. Each digit owns a slot of 2^DIV_W clk
// cycles. A full frame is NDIG slots. The driver adds per-digit blanking,
// PWM brightness within each slot, and double-buffered updates: a load is
// captured into a pending buffer and only committed to the active (displayed)
// buffer at the frame boundary. A frame never mixes old and new content.
//
// Parameters
//   NDIG   number of digits scanned (2..16)
//   DIV_W  prescaler width; one digit slot lasts 2^DIV_W cycles
//   BR_W   brightness code width (1..DIV_W)
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   load        single-cycle strobe; captures digits/blank/bright
//   digits      NDIG bytes; byte i = {dp, g..a}, active-low, passed through
//   blank       per-digit blank; 1 = digit dark
//   bright      duty code; 0 = off, all-ones = always on
//   an          active-low anode enables (registered, at most one low)
//   sseg        active-low segments (registered)
//   frame_tick  one-cycle pulse on the first cycle of each frame
//   pending     high while a captured load awaits commit
// -----------------------------------------------------------------------------
module sseg_scan_mux #(
  parameter int NDIG  = 8,
  parameter int DIV_W = 16,
  parameter int BR_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [NDIG*8-1:0]   digits,
  input  logic [NDIG-1:0]     blank,
  input  logic [BR_W-1:0]     bright,
  output logic [NDIG-1:0]     an,
  output logic [7:0]          sseg,
  output logic                frame_tick,
  output logic                pending
);

  localparam int              IDX_W    = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] p;
  logic [IDX_W-1:0] idx;
  logic             slot_end;   // last cycle of the current digit slot
  logic             commit;     // last cycle of the frame; buffers swap on this edge

  assign slot_end = &p;
  assign commit   = slot_end && (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, regardless of the
  // order in which the simulator evaluates the always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p   <= '0;
      idx <= '0;
    end else begin
      p <= p + 1'b1;
      if (slot_end) begin
        // idx wraps explicitly because NDIG need not be a power of two.
        if (idx == LAST_IDX) idx <= '0;
        else                 idx <= idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer
  // ---------------------------------------------------------------------------
  logic [NDIG*8-1:0] pend_digits;
  logic [NDIG-1:0]   pend_blank;
  logic [BR_W-1:0]   pend_bright;

  logic [NDIG*8-1:0] act_digits;
  logic [NDIG-1:0]   act_blank;
  logic [BR_W-1:0]   act_bright;

  // NOTE: both buffers are plain flops with explicit reset values, not a
  // RAM. The active buffer resets to "all digits blank" so the display stays
  // dark until the first real commit, which a RAM without reset can't ensure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_blank  <= '0;
      pend_bright <= '0;
      pending     <= 1'b0;
    end else begin
      // The last load before a commit wins.
      if (load) begin
        pend_digits <= digits;
        pend_blank  <= blank;
        pend_bright <= bright;
      end
      // A load on the commit edge goes straight to the active buffer below,
      // so it must not leave the pending flag set.
      if (commit)    pending <= 1'b0;
      else if (load) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_digits <= '1;
      act_blank  <= '1;
      act_bright <= '1;
    end else if (commit) begin
      if (load) begin
        // Live inputs bypass the pending buffer so a load on the frame
        // boundary is visible in the frame that starts right now.
        act_digits <= digits;
        act_blank  <= blank;
        act_bright <= bright;
      end else if (pending) begin
        act_digits <= pend_digits;
        act_blank  <= pend_blank;
        act_bright <= pend_bright;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Brightness and output decode
  // ---------------------------------------------------------------------------
  logic [BR_W-1:0] ph;        // coarse phase within the slot
  logic            lit;
  logic            show;
  logic [7:0]      cur_digit;
  logic            cur_blank;
  logic [NDIG-1:0] an_d;
  logic [7:0]      sseg_d;

  assign ph = p[DIV_W-1 -: BR_W];

  // NOTE: every variable driven here gets a default at the top of the block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_digit = 8'hFF;
    cur_blank = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = act_digits[8*i +: 8];
        cur_blank = act_blank[i];
      end
    end

    // All-ones is forced on so the top code really means 100 % duty,
    // rather than (2^BR_W - 1) / 2^BR_W.
    lit  = (&act_bright) || (ph < act_bright);
    show = !cur_blank && lit;

    an_d   = '1;
    sseg_d = 8'hFF;
    for (int i = 0; i < NDIG; i++) begin
      if (show && (idx == IDX_W'(i))) an_d[i] = 1'b0;
    end
    if (show) sseg_d = cur_digit;
  end

  // Outputs are registered to give glitch-free pins; they lag (idx, p,
  // active buffer) by one cycle. frame_tick is the registered commit, so
  // it is high in the first cycle of the new frame and low after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= '1;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      sseg       <= sseg_d;
      frame_tick <= commit;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_mux
//
// Self-checking bench for sseg_scan_mux with NDIG=4, DIV_W=4, BR_W=2
// (16-cycle slots, 64-cycle frames). A reference model that tracks time
// since reset as a plain cycle count predicts an, sseg, frame_tick and
// pending every cycle. A table of display settings is checked by counting
// lit cycles per digit over a full frame. Hand-written sequences cover
// the frame-boundary and reset corner cases.
// -----------------------------------------------------------------------------
module tb_sseg_scan_mux;

  localparam int NDIG  = 4;
  localparam int DIV_W = 4;
  localparam int BR_W  = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = 64;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        load   = 1'b0;
  logic [31:0] digits = '0;
  logic [3:0]  blank  = '0;
  logic [1:0]  bright = '0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;
  logic        pending;

  sseg_scan_mux #(.NDIG(NDIG), .DIV_W(DIV_W), .BR_W(BR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits     (digits),
    .blank      (blank),
    .bright     (bright),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] digits;
    logic [3:0]  blank;
    logic [1:0]  bright;
  } buf_t;

  typedef struct {
    logic [31:0]     digits;
    logic [3:0]      blank;
    logic [1:0]      bright;
    logic [3:0][7:0] exp_on;   // lit cycles per digit in one frame
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_t;            // clock edges since reset release
  bit          m_pflag;
  buf_t        m_pend;
  buf_t        m_act;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;
  logic        exp_ft;
  logic        exp_pend;

  bit seen_11, seen_22, seen_33;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t            = 0;
    m_pflag        = 1'b0;
    m_pend.digits  = '0;
    m_pend.blank   = '0;
    m_pend.bright  = '0;
    m_act.digits   = 32'hFFFF_FFFF;
    m_act.blank    = 4'hF;
    m_act.bright   = 2'd3;
    exp_an         = 4'hF;
    exp_sseg       = 8'hFF;
    exp_ft         = 1'b0;
    exp_pend       = 1'b0;
  endtask

  // One clock edge of the reference: display what the current position in
  // the frame calls for, then apply buffer updates.
  task automatic model_edge();
    int   pos   = m_t % SLOT;
    int   slot  = (m_t / SLOT) % NDIG;
    bit   lit   = (m_act.bright == 2'd3) || ((pos / 4) < int'(m_act.bright));
    bit   last  = (m_t % FRAME) == FRAME - 1;
    buf_t live;
    live.digits = digits;
    live.blank  = blank;
    live.bright = bright;
    if (!m_act.blank[slot] && lit) begin
      exp_an   = 4'hF ^ (4'b0001 << slot);
      exp_sseg = m_act.digits[slot*8 +: 8];
    end else begin
      exp_an   = 4'hF;
      exp_sseg = 8'hFF;
    end
    exp_ft = last;
    if (last) begin
      if (load)         m_act = live;
      else if (m_pflag) m_act = m_pend;
      m_pflag = 1'b0;
    end else if (load) begin
      m_pflag = 1'b1;
    end
    if (load) m_pend = live;
    exp_pend = m_pflag;
    m_t++;
  endtask

  task automatic check_outputs();
    check("an", an, exp_an);
    check("sseg", sseg, exp_sseg);
    check("frame_tick", frame_tick, exp_ft);
    check("pending", pending, exp_pend);
    if (an == 4'b1110 && sseg == 8'h11) seen_11 = 1'b1;
    if (an == 4'b1110 && sseg == 8'h22) seen_22 = 1'b1;
    if (an == 4'b1110 && sseg == 8'h33) seen_33 = 1'b1;
  endtask

  // One clock: model steps on the edge, DUT outputs compared on the
  // falling edge. Callers change inputs only after this returns.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [3:0] b, input logic [1:0] br);
    digits = d;
    blank  = b;
    bright = br;
    load   = 1'b1;
    cycle();
    load   = 1'b0;
  endtask

  // Run until the model sits at frame position r (bounded by one frame).
  task automatic advance_to(input int r);
    int n = 0;
    while ((m_t % FRAME) != r && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    check("advance_bound", ((m_t % FRAME) == r), 1);
  endtask

  vec_t tbl [6];
  int   ticks [$];

  initial begin
    int on_cnt [4];
    int bad;
    int dark;
    bit hit;

    tbl[0].digits = 32'h0C0B0A09; tbl[0].blank = 4'b0000; tbl[0].bright = 2'd3;
    tbl[0].exp_on = {8'd16, 8'd16, 8'd16, 8'd16};
    tbl[1].digits = 32'h0C0B0A09; tbl[1].blank = 4'b0000; tbl[1].bright = 2'd2;
    tbl[1].exp_on = {8'd8, 8'd8, 8'd8, 8'd8};
    tbl[2].digits = 32'h12345678; tbl[2].blank = 4'b0100; tbl[2].bright = 2'd3;
    tbl[2].exp_on = {8'd16, 8'd0, 8'd16, 8'd16};
    tbl[3].digits = 32'h12345678; tbl[3].blank = 4'b0000; tbl[3].bright = 2'd0;
    tbl[3].exp_on = {8'd0, 8'd0, 8'd0, 8'd0};
    tbl[4].digits = 32'hC0F9A4B0; tbl[4].blank = 4'b1001; tbl[4].bright = 2'd1;
    tbl[4].exp_on = {8'd0, 8'd4, 8'd4, 8'd0};
    tbl[5].digits = 32'h0C0B0A09; tbl[5].blank = 4'b1111; tbl[5].bright = 2'd3;
    tbl[5].exp_on = {8'd0, 8'd0, 8'd0, 8'd0};

    // Reset and first commit: dark for 200 cycles, ticks at 64/128/192.
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    dark  = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (frame_tick) ticks.push_back(i);
      if (an !== 4'hF || sseg !== 8'hFF) dark++;
    end
    check("init_not_dark", dark, 0);
    check("init_tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      check("init_tick0", ticks[0], 64);
      check("init_tick1", ticks[1], 128);
      check("init_tick2", ticks[2], 192);
    end

    // Table: basic scan, brightness and blanking over a whole frame.
    for (int i = 0; i < 6; i++) begin
      do_load(tbl[i].digits, tbl[i].blank, tbl[i].bright);
      advance_to(0);
      for (int d = 0; d < 4; d++) on_cnt[d] = 0;
      bad = 0;
      repeat (FRAME) begin
        cycle();
        hit = 1'b0;
        for (int d = 0; d < 4; d++) begin
          if (an == (4'hF ^ (4'b0001 << d)) && sseg == tbl[i].digits[8*d +: 8]) begin
            on_cnt[d]++;
            hit = 1'b1;
          end
        end
        if (!hit && !(an == 4'hF && sseg == 8'hFF)) bad++;
      end
      for (int d = 0; d < 4; d++)
        check($sformatf("tbl%0d_on%0d", i, d), on_cnt[d], int'(tbl[i].exp_on[d]));
      check($sformatf("tbl%0d_bad", i), bad, 0);
    end

    // Frame-synchronous update: two loads mid-frame, the last one wins.
    do_load(32'h0C0B0A09, 4'b0000, 2'd3);
    advance_to(20);
    do_load(32'h0C0B0A11, 4'b0000, 2'd3);
    repeat (3) cycle();
    do_load(32'h0C0B0A22, 4'b0000, 2'd3);
    check("upd_pending_high", pending, 1);
    seen_11 = 1'b0;
    seen_22 = 1'b0;
    advance_to(0);
    check("upd_pending_cleared", pending, 0);
    repeat (FRAME) cycle();
    check("upd_never_11", seen_11, 0);
    check("upd_shows_22", seen_22, 1);

    // Load on the commit edge takes effect in the frame it starts.
    advance_to(FRAME - 1);
    digits  = 32'h0C0B0A33;
    load    = 1'b1;
    cycle();
    load    = 1'b0;
    check("edge_load_tick", frame_tick, 1);
    check("edge_load_no_pending", pending, 0);
    seen_33 = 1'b0;
    repeat (FRAME) cycle();
    check("edge_load_shows_33", seen_33, 1);

    // Randomised loads at random times, checked every cycle by the model.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 90)) cycle();
      do_load($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    repeat (FRAME + 2) cycle();

    // Mid-frame reset with a load pending: asynchronous dark, stays dark.
    advance_to(36);
    do_load(32'h01020304, 4'b0000, 2'd3);
    cycle();
    check("rst_pending_before", pending, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_an", an, 4'hF);
    check("rst_async_sseg", sseg, 8'hFF);
    check("rst_async_pending", pending, 0);
    check("rst_async_tick", frame_tick, 0);
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    dark  = 0;
    repeat (200) begin
      cycle();
      if (an !== 4'hF || sseg !== 8'hFF) dark++;
    end
    check("rst_stays_dark", dark, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Parametrised, time-multiplexed seven-segment display driver for NDIG digits with active-low anodes and segments. It adds per-digit blanking, PWM brightness control and frame-synchronous double-buffered updates, so new digit data is never shown part-way through a scan. It sits between the display-content logic (scrolling, counters) and the board's anode and segment pins.

## Interface

**Parameters**
- NDIG, 8: number of digits scanned; legal range 2..16.
- DIV_W, 16: prescaler width; each digit slot lasts 2^DIV_W clk cycles.
- BR_W, 4: brightness code width; legal range 1..DIV_W.

**Ports**
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- load, input, 1: single-cycle strobe; captures digits, blank and bright into the pending buffer.
- digits, input, NDIG*8: digit i is bits [8i+7:8i]. Bit 7 is dp, bits 6:0 are g..a. All active-low; passed through unchanged.
- blank, input, NDIG: 1 means digit i is dark.
- bright, input, BR_W: duty code. 0 means off; all-ones means 100%.
- an, output, NDIG: active-low anode enables, registered.
- sseg, output, 8: active-low segments, registered.
- frame_tick, output, 1: one-cycle pulse on the first cycle of each frame.
- pending, output, 1: high while a captured load has not yet been committed.

## Operation

**Scan counters**
- Prescaler p is DIV_W bits wide, increments every cycle and wraps.
- Digit index idx is $clog2(NDIG) bits wide. It increments on the edge where p goes from all-ones to 0, and wraps from NDIG-1 to 0.

**Buffers**
- Two register sets hold digits, blank and bright: pending_buf and active_buf.
- load=1: pending_buf ← inputs, and the pending flag is set. A later load before commit overwrites pending_buf; the last load wins.
- Commit happens on the edge that moves (idx, p) from (NDIG-1, all-ones) to (0, 0).
  - If load=1 on that edge, active_buf ← the live inputs directly and the pending flag is cleared.
  - Else, if the pending flag is set, active_buf ← pending_buf and the pending flag is cleared.
  - Else, active_buf is unchanged.
- The scan never shows a mixture of old and new data within one frame.

**Brightness**
- Slot phase ph = p[DIV_W-1 : DIV_W-BR_W].
- Lit condition: bright == all-ones, or ph < bright.
- A lit slot is on for bright × 2^(DIV_W-BR_W) cycles per slot, except all-ones, which is on for the full slot.

**Output decode** (next-state values loaded into the output registers)
- If active blank[idx]=0 and lit: an = all-ones except bit idx = 0, and sseg = active digits[idx].
- Otherwise: an = all-ones and sseg = 8'hFF.
- At most one an bit is ever low.

**Frame tick**
- frame_tick=1 exactly in the cycle where idx=0 and p=0, i.e. immediately after a commit edge.

**Reset values**
- p=0, idx=0, pending flag=0, pending_buf=0.
- active_buf: digits all 8'hFF, blank all ones, bright all ones.
- an all ones, sseg 8'hFF, frame_tick 0, pending 0.
- With this reset state the display is dark until the first commit.

## Timing

- Slot length is 2^DIV_W cycles; frame length is NDIG·2^DIV_W cycles.
- At 50 MHz with NDIG=8 and DIV_W=16 the refresh rate is about 95 Hz per digit.
- an and sseg lag the internal state (idx, p, active_buf) by exactly 1 cycle.
  - Example: the first cycle of slot k shows the decode of the last cycle of slot k-1.
- Worst-case load-to-display latency is one frame plus 2 cycles: 1 cycle for the commit edge and 1 for the output register.
- pending rises in the cycle after load. It falls in the cycle after the commit edge, together with frame_tick=1.
- load asserted on the commit edge never sets pending.
- reset asserted mid-frame immediately forces all reset values, discards pending_buf, and restarts the scan at idx=0, p=0 after release.

## Test plan

Bench parameters: NDIG=4, DIV_W=4, BR_W=2. Frame = 64 cycles.

1. **Reset and first commit.** Release reset and hold load=0. Required: an=4'hF and sseg=8'hFF for 200 cycles; frame_tick pulses at cycles 64, 128 and 192 after release; pending stays 0.
2. **Basic scan.** Load digits {8'h0C, 8'h0B, 8'h0A, 8'h09}, blank=0, bright=3. Required:
   - After commit, an follows 1110 → 1101 → 1011 → 0111, each for 16 cycles.
   - sseg = 09, 0A, 0B, 0C respectively.
   - an changes 1 cycle after idx changes.
3. **Frame-synchronous update.** In mid-frame, issue two loads: first digit0=8'h11, then digit0=8'h22. Required: pending=1 until the commit; the old data is shown for the rest of the frame; the next frame shows 8'h22 and never 8'h11.
4. **Load on commit edge.** Assert load with digit0=8'h33 on the (3, 15) to (0, 0) edge. Required: digit0 shows 8'h33 in the same new frame, and pending stays 0.
5. **Brightness and blanking.**
   - bright=2: each lit slot is on for 8 of 16 cycles (phases 0 and 1).
   - bright=0: an stays 4'hF.
   - blank=4'b0100: digit 2 has an=4'hF and sseg=8'hFF during its slot; the other digits are unaffected.
6. **Mid-frame reset.** Assert reset during slot 2 with pending=1. Required: an=4'hF, sseg=8'hFF and pending=0 asynchronously, and the display stays dark after release until the next load commits.
